sysid_read_master: RTL and testbench

SYSID_READ_MASTER -- requirements
Module: sysid_read_master

---
 rtl/sysid_pkg.sv | 23 ++
 rtl/sysid_stall_timer.sv | 30 +++
 rtl/sysid_read_master.sv | 139 +++++++++++++
 tb/tb_sysid_read_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared state encoding, default expected ID words and a counter-width helper
// for the system-ID read checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD0_REQ = 3'd1,
    ST_RD0_LAT = 3'd2,
    ST_RD1_REQ = 3'd3,
    ST_RD1_LAT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_FIN     = 3'd6
  } sysid_state_t;

  localparam logic [31:0] DEF_EXP_WORD0 = 32'd0;
  localparam logic [31:0] DEF_EXP_WORD1 = 32'd1461116254;
  localparam int unsigned MAX_ATTEMPTS  = 3;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sysid_stall_timer.sv
// Counts consecutive waitrequest stalls of the outstanding read and flags
// expiry once TIMEOUT_CYCLES stalls have accumulated.
module sysid_stall_timer
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_stall,
  output logic o_expired
);
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Any non-stall cycle (acceptance or leaving the request state) clears the count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_stall) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= '0;
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/sysid_read_master.sv
// Avalon-MM system-ID checker: reads words 0 and 1 and compares them with EXP_WORD0/1.
// Optional SYSID_READ_RETRY_EN: a mismatch re-runs the read pair, up to three attempts.
module sysid_read_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_WORD0      = DEF_EXP_WORD0,
  parameter logic [31:0] EXP_WORD1      = DEF_EXP_WORD1,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic [31:0] i_avm_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_match,
  output logic        o_timeout,
  output logic [31:0] o_word0,
  output logic [31:0] o_word1
);
  localparam bit         NO_LAT   = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LAST = NO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);

  sysid_state_t r_state, w_state_next;
  logic [1:0]   r_lat_cnt;
  logic [31:0]  r_word0, r_word1;
  logic         r_busy, r_done, r_match, r_timeout;
  logic         w_in_req, w_in_lat, w_stall, w_expired, w_accept, w_lat_last;
  logic         w_start_ok, w_words_ok, w_cap0, w_cap1, w_retry;

  assign w_in_req   = (r_state == ST_RD0_REQ) || (r_state == ST_RD1_REQ);
  assign w_in_lat   = (r_state == ST_RD0_LAT) || (r_state == ST_RD1_LAT);
  assign w_stall    = w_in_req && !w_expired && i_avm_waitrequest;
  assign w_accept   = w_in_req && !w_expired && !i_avm_waitrequest;
  assign w_lat_last = (r_lat_cnt == LAT_LAST);
  assign w_start_ok = (r_state == ST_IDLE) && !r_busy && i_start;
  assign w_words_ok = (r_word0 == EXP_WORD0) && (r_word1 == EXP_WORD1);

  // Zero latency samples data with acceptance; otherwise on the last latency cycle.
  assign w_cap0 = NO_LAT ? ((r_state == ST_RD0_REQ) && w_accept)
                         : ((r_state == ST_RD0_LAT) && w_lat_last);
  assign w_cap1 = NO_LAT ? ((r_state == ST_RD1_REQ) && w_accept)
                         : ((r_state == ST_RD1_LAT) && w_lat_last);

  sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_stall  (w_stall),
    .o_expired(w_expired)
  );

`ifdef SYSID_READ_RETRY_EN
  logic [1:0] r_retry_cnt;

  assign w_retry = !w_words_ok && (r_retry_cnt < 2'(MAX_ATTEMPTS - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_retry_cnt <= '0;
    end else if (w_start_ok) begin
      r_retry_cnt <= '0;
    end else if ((r_state == ST_CHECK) && w_retry) begin
      r_retry_cnt <= r_retry_cnt + 2'd1;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_state_next = ST_RD0_REQ;
      ST_RD0_REQ: begin
        if (w_expired)     w_state_next = ST_FIN;
        else if (w_accept) w_state_next = NO_LAT ? ST_RD1_REQ : ST_RD0_LAT;
      end
      ST_RD0_LAT: if (w_lat_last) w_state_next = ST_RD1_REQ;
      ST_RD1_REQ: begin
        if (w_expired)     w_state_next = ST_FIN;
        else if (w_accept) w_state_next = NO_LAT ? ST_CHECK : ST_RD1_LAT;
      end
      ST_RD1_LAT: if (w_lat_last) w_state_next = ST_CHECK;
      ST_CHECK:   w_state_next = w_retry ? ST_RD0_REQ : ST_FIN;
      ST_FIN:     w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
      r_word0   <= '0;
      r_word1   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == ST_FIN);
      r_lat_cnt <= (w_in_lat && !w_lat_last) ? r_lat_cnt + 2'd1 : 2'd0;
      if (w_cap0) r_word0 <= i_avm_readdata;
      if (w_cap1) r_word1 <= i_avm_readdata;
      if (r_state == ST_CHECK) r_match <= w_words_ok;
      // Busy falls together with the done pulse so a new start is only taken afterwards.
      if (w_start_ok) begin
        r_busy    <= 1'b1;
        r_match   <= 1'b0;
        r_timeout <= 1'b0;
        r_word0   <= '0;
        r_word1   <= '0;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_expired && w_in_req) begin
        r_timeout <= 1'b1;
        r_match   <= 1'b0;
      end
    end
  end

  assign o_avm_read    = w_in_req && !w_expired;
  assign o_avm_address = (r_state == ST_RD1_REQ);
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_match       = r_match;
  assign o_timeout     = r_timeout;
  assign o_word0       = r_word0;
  assign o_word1       = r_word1;

endmodule

// File: tb/tb_sysid_read_master.sv
// Scoreboard bench for sysid_read_master: one zero-latency and one two-cycle-latency
// instance, each driven by a small Avalon slave model with programmable stalls.
`timescale 1ns/1ps
module tb_sysid_read_master;
  localparam logic [31:0] EXP0 = 32'd0;
  localparam logic [31:0] EXP1 = 32'd1461116254;
  localparam int          TO   = 4;
`ifdef SYSID_READ_RETRY_EN
  localparam int ATTEMPTS_MAX = 3;
`else
  localparam int ATTEMPTS_MAX = 1;
`endif

  typedef struct {
    bit          m;
    bit          t;
    logic [31:0] w0;
    logic [31:0] w1;
    int          cyc;
    int          nreads;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start       [2];
  logic        avm_address [2];
  logic        avm_read    [2];
  logic        waitreq     [2];
  logic [31:0] readdata    [2];
  logic        busy        [2];
  logic        done        [2];
  logic        match       [2];
  logic        timeout     [2];
  logic [31:0] word0       [2];
  logic [31:0] word1       [2];

  int unsigned stall_n  [2];
  logic [31:0] mem0     [2];
  logic [31:0] mem1     [2];
  int unsigned sl_stall [2] = '{0, 0};
  int          sl_cd    [2] = '{0, 0};
  logic [31:0] sl_data  [2] = '{32'h0, 32'h0};
  int          reads_acc[2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          addr_err [2] = '{0, 0};
  logic        pend     [2] = '{1'b0, 1'b0};
  logic        paddr    [2] = '{1'b0, 1'b0};

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sysid_read_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(start[0]),
    .o_avm_address(avm_address[0]), .o_avm_read(avm_read[0]),
    .i_avm_waitrequest(waitreq[0]), .i_avm_readdata(readdata[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_match(match[0]), .o_timeout(timeout[0]),
    .o_word0(word0[0]), .o_word1(word1[0])
  );

  sysid_read_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start[1]),
    .o_avm_address(avm_address[1]), .o_avm_read(avm_read[1]),
    .i_avm_waitrequest(waitreq[1]), .i_avm_readdata(readdata[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_match(match[1]), .o_timeout(timeout[1]),
    .o_word0(word0[1]), .o_word1(word1[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Slave: data is only valid exactly when the master is meant to sample it.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      waitreq[d]  = avm_read[d] && (sl_stall[d] < stall_n[d]);
      readdata[d] = 32'hDEADBEEF;
      if (lat_of(d) == 0) begin
        if (avm_read[d] && !waitreq[d]) readdata[d] = avm_address[d] ? mem1[d] : mem0[d];
      end else if (sl_cd[d] == 1) begin
        readdata[d] = sl_data[d];
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      sl_stall[d] <= (avm_read[d] && waitreq[d]) ? sl_stall[d] + 1 : 0;
      if (avm_read[d] && !waitreq[d]) begin
        sl_data[d]   <= avm_address[d] ? mem1[d] : mem0[d];
        sl_cd[d]     <= lat_of(d);
        reads_acc[d] <= reads_acc[d] + 1;
      end else if (sl_cd[d] != 0) begin
        sl_cd[d] <= sl_cd[d] - 1;
      end
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (pend[d] && (avm_address[d] != paddr[d])) addr_err[d] <= addr_err[d] + 1;
      pend[d]  <= avm_read[d] && waitreq[d];
      paddr[d] <= avm_address[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input int d, input logic [31:0] w0,
                         input logic [31:0] w1, input int unsigned stalls, input bit poke);
    exp_t e, got_e;
    int   cyc, attempts, r0, dn0, ae0;
    mem0[d]    = w0;
    mem1[d]    = w1;
    stall_n[d] = stalls;
    e.t        = (stalls >= TO);
    e.m        = !e.t && (w0 == EXP0) && (w1 == EXP1);
    attempts   = (e.t || e.m) ? 1 : ATTEMPTS_MAX;
    e.w0       = e.t ? 32'd0 : w0;
    e.w1       = e.t ? 32'd0 : w1;
    e.cyc      = e.t ? TO + 3 : attempts * (2 * (lat_of(d) + 1) + 1 + 2 * int'(stalls)) + 2;
    e.nreads   = e.t ? 0 : 2 * attempts;
    exp_q.push_back(e);
    r0  = reads_acc[d];
    dn0 = done_cnt[d];
    ae0 = addr_err[d];
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    while (!done[d] && cyc < 300) begin
      if (e.t && cyc == TO)     check({tag, "_read_held"}, 32'(avm_read[d]), 32'd1);
      if (e.t && cyc == TO + 1) check({tag, "_read_drop"}, 32'(avm_read[d]), 32'd0);
      start[d] = poke && (cyc == 2 || cyc == e.cyc - 1);
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    check({tag, "_done_seen"}, 32'(done[d]), 32'd1);
    got_e = exp_q.pop_front();
    check({tag, "_cycles"},  32'(cyc), 32'(got_e.cyc));
    check({tag, "_match"},   32'(match[d]), 32'(got_e.m));
    check({tag, "_timeout"}, 32'(timeout[d]), 32'(got_e.t));
    check({tag, "_word0"},   word0[d], got_e.w0);
    check({tag, "_word1"},   word1[d], got_e.w1);
    $display("[TB] txn %s dut%0d: done at cycle %0d match=%0d timeout=%0d",
             tag, d, cyc, match[d], timeout[d]);
    repeat (4) @(negedge clk);
    check({tag, "_reads"},     32'(reads_acc[d] - r0), 32'(got_e.nreads));
    check({tag, "_done_once"}, 32'(done_cnt[d] - dn0), 32'd1);
    check({tag, "_addr_hold"}, 32'(addr_err[d] - ae0), 32'd0);
    check({tag, "_idle"},      32'(busy[d]), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = '{1'b0, 1'b0};
    stall_n    = '{0, 0};
    mem0       = '{EXP0, EXP0};
    mem1       = '{EXP1, EXP1};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d),  32'(busy[d]), 32'd0);
      check($sformatf("rst_done%0d", d),  32'(done[d]), 32'd0);
      check($sformatf("rst_read%0d", d),  32'(avm_read[d]), 32'd0);
      check($sformatf("rst_addr%0d", d),  32'(avm_address[d]), 32'd0);
      check($sformatf("rst_match%0d", d), 32'(match[d]), 32'd0);
      check($sformatf("rst_tmo%0d", d),   32'(timeout[d]), 32'd0);
      check($sformatf("rst_w1_%0d", d),   word1[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_txn("nominal_l0",  0, EXP0, EXP1, 0, 1'b0);
    run_txn("stall3_l2",   1, EXP0, EXP1, 3, 1'b0);
    run_txn("bad_word1",   0, EXP0, 32'h12345678, 0, 1'b0);
    run_txn("stuck_wait",  0, EXP0, EXP1, 1000, 1'b0);
    run_txn("start_poke",  0, EXP0, EXP1, 0, 1'b1);
    run_txn("bad_word0",   1, 32'hA5A5A5A5, EXP1, 1, 1'b0);

    // Reset while dut1 sits in its second latency phase.
    mem0[1] = EXP0; mem1[1] = EXP1; stall_n[1] = 0;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy[1]), 32'd0);
    check("midrst_read", 32'(avm_read[1]), 32'd0);
    check("midrst_done", 32'(done[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_late_data", word1[1], 32'd0);
    $display("[TB] txn midrst dut1: reset during read, outputs cleared");
    run_txn("after_rst", 1, EXP0, EXP1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
